// File: rtl/if_stage_bp_pkg.sv
// ============================================================================
// Module      : if_stage_bp_pkg
// Description : Shared types and helpers for the BTB-predicting fetch stage:
//               PC-select encodings and the 2-bit direction counter update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_bp_pkg;

    // Sources feeding the next-PC mux
    typedef enum logic [1:0] {
        PC_4    = 2'd0,   // sequential fetch, if_pc + 4
        PC_ALU  = 2'd1,   // EX misprediction redirect
        PC_TGT  = 2'd2,   // ID-resolved direct jump target
        PC_PRED = 2'd3    // BTB predicted target
    } pc_sel_e;

    localparam int PC_MUX_NUM_INPUTS = 4;

    // Counter value given to a freshly allocated entry (weakly taken)
    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

    // Saturating 2-bit counter step toward the resolved direction
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != 2'b11) result = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_bp_btb.sv
// ============================================================================
// Module      : if_stage_bp_btb
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               direction counters. Combinational lookup, one synchronous
//               training port. Reset clears only the valid bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_bp_btb
    import if_stage_bp_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic             r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
    logic [29:0]      r_target [BTB_ENTRIES];
    logic [1:0]       r_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX-1:0]   w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_unused_bits;

    // Word-aligned addresses: bits [1:0] never take part in index, tag or target
    assign w_unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign w_lk_idx = lookup_pc[IDX+1:2];
    assign w_lk_tag = lookup_pc[31:IDX+2];
    assign w_up_idx = upd_pc[IDX+1:2];
    assign w_up_tag = upd_pc[31:IDX+2];

    // Read port: taken prediction needs a tag hit and the counter's MSB set
    always_comb begin
        w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        lookup_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
        lookup_target = {r_target[w_lk_idx], 2'b00};
    end

    // Hit check for training uses the contents before this edge's write
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Training port: counter step on hit, allocate on taken miss; reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= ctr_update(r_ctr[w_up_idx], upd_taken);
                if (upd_taken) begin
                    r_target[w_up_idx] <= upd_target[31:2];
                end
            end else if (upd_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= upd_target[31:2];
                r_ctr[w_up_idx]    <= CTR_WEAK_TAKEN;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_stage_bp.sv
// ============================================================================
// Module      : if_stage_bp
// Description : Instruction-fetch stage. Selects the next PC from EX
//               redirects, ID jump targets, BTB predictions or PC+4, and
//               holds the PC of the instruction currently being fetched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_bp
    import if_stage_bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter int          PRED_MODE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_stall,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        id_target_taken,
    input  logic [31:0] id_target,
    input  logic        ex_upd_valid,
    input  logic [31:0] ex_upd_pc,
    input  logic        ex_upd_taken,
    input  logic [31:0] ex_upd_target,
    output logic [31:0] if_addr,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);

    logic [31:0] r_pc;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;
    pc_sel_e     w_pc_sel;
    logic        w_hold;
    logic [31:0] w_mux_out;

    if (PRED_MODE != 0) begin : g_btb
        if_stage_bp_btb #(
            .BTB_ENTRIES (BTB_ENTRIES)
        ) u_btb (
            .clk           (clk),
            .rst           (rst),
            .lookup_pc     (r_pc),
            .lookup_taken  (w_pred_taken),
            .lookup_target (w_pred_target),
            .upd_valid     (ex_upd_valid),
            .upd_pc        (ex_upd_pc),
            .upd_taken     (ex_upd_taken),
            .upd_target    (ex_upd_target)
        );
    end else begin : g_static
        // Static not-taken: the training port is deliberately left unconnected
        logic w_unused_upd;
        assign w_unused_upd  = ^{ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target};
        assign w_pred_taken  = 1'b0;
        assign w_pred_target = 32'h0;
    end

    // Next-PC priority: EX stall, EX redirect, ID stall, ID jump, prediction, PC+4
    always_comb begin
        w_hold   = 1'b0;
        w_pc_sel = PC_4;
        if (ex_stall) begin
            w_hold = 1'b1;
        end else if (ex_redirect) begin
            w_pc_sel = PC_ALU;
        end else if (id_stall) begin
            w_hold = 1'b1;
        end else if (id_target_taken) begin
            w_pc_sel = PC_TGT;
        end else if (w_pred_taken) begin
            w_pc_sel = PC_PRED;
        end
    end

    // PC source mux; redirect PCs pass through unaligned
    always_comb begin
        w_mux_out = r_pc + 32'd4;
        case (w_pc_sel)
            PC_4:    w_mux_out = r_pc + 32'd4;
            PC_ALU:  w_mux_out = ex_redirect_pc;
            PC_TGT:  w_mux_out = id_target;
            PC_PRED: w_mux_out = w_pred_target;
            default: w_mux_out = r_pc + 32'd4;
        endcase
    end

    // A stall makes memory re-read the current PC
    assign if_addr = w_hold ? r_pc : w_mux_out;

    // PC register: loads next PC every cycle, RESET_PC on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= if_addr;
        end
    end

    assign if_pc          = r_pc;
    assign if_pred_taken  = w_pred_taken;
    assign if_pred_target = w_pred_taken ? w_pred_target : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_if_stage_bp.sv
// ============================================================================
// Module      : tb_if_stage_bp
// Description : Self-checking bench for if_stage_bp. Two instances (BTB
//               prediction and static not-taken) share stimulus; a
//               behavioural fetch/BTB model supplies every expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage_bp;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam int          NENT   = 16;
    localparam int          IDXB   = 4;

    logic        clk;
    logic        rst;
    logic        ex_stall, id_stall, ex_redirect, id_target_taken;
    logic [31:0] ex_redirect_pc, id_target;
    logic        ex_upd_valid, ex_upd_taken;
    logic [31:0] ex_upd_pc, ex_upd_target;

    logic [31:0] if_addr, if_pc, if_pred_target;
    logic        if_pred_taken;
    logic [31:0] if_addr0, if_pc0, if_pred_target0;
    logic        if_pred_taken0;

    int total = 0;
    int bad   = 0;

    // Model state: one slot per index, remembering the full branch PC
    logic        mv   [NENT];
    logic [31:0] mpc  [NENT];
    logic [31:0] mtgt [NENT];
    int          mctr [NENT];
    logic [31:0] m_pc;
    logic [31:0] m_pc0;

    if_stage_bp #(.RESET_PC(RST_PC), .BTB_ENTRIES(NENT), .PRED_MODE(1)) dut (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .id_stall(id_stall),
        .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
        .id_target_taken(id_target_taken), .id_target(id_target),
        .ex_upd_valid(ex_upd_valid), .ex_upd_pc(ex_upd_pc),
        .ex_upd_taken(ex_upd_taken), .ex_upd_target(ex_upd_target),
        .if_addr(if_addr), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target)
    );

    if_stage_bp #(.RESET_PC(RST_PC), .BTB_ENTRIES(NENT), .PRED_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .id_stall(id_stall),
        .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
        .id_target_taken(id_target_taken), .id_target(id_target),
        .ex_upd_valid(ex_upd_valid), .ex_upd_pc(ex_upd_pc),
        .ex_upd_taken(ex_upd_taken), .ex_upd_target(ex_upd_target),
        .if_addr(if_addr0), .if_pc(if_pc0), .if_pred_taken(if_pred_taken0),
        .if_pred_target(if_pred_target0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predicted direction/target for a fetch PC from the model table
    function automatic void m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
        int idx;
        logic hit;
        idx = int'((pc >> 2) % NENT);
        hit = mv[idx] && ((mpc[idx] >> (IDXB + 2)) == (pc >> (IDXB + 2)));
        pt  = hit && (mctr[idx] >= 2);
        tgt = pt ? (mtgt[idx] & 32'hFFFF_FFFC) : 32'h0;
    endfunction

    // Next fetch address from the priority rules
    function automatic logic [31:0] m_next(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        if (ex_stall)        return pc;
        if (ex_redirect)     return ex_redirect_pc;
        if (id_stall)        return pc;
        if (id_target_taken) return id_target;
        if (pt)              return tgt;
        return pc + 32'd4;
    endfunction

    function automatic void m_train();
        int idx;
        logic hit;
        if (!ex_upd_valid) return;
        idx = int'((ex_upd_pc >> 2) % NENT);
        hit = mv[idx] && ((mpc[idx] >> (IDXB + 2)) == (ex_upd_pc >> (IDXB + 2)));
        if (hit) begin
            if (ex_upd_taken) begin
                mctr[idx] = (mctr[idx] < 3) ? mctr[idx] + 1 : 3;
                mtgt[idx] = ex_upd_target;
            end else begin
                mctr[idx] = (mctr[idx] > 0) ? mctr[idx] - 1 : 0;
            end
        end else if (ex_upd_taken) begin
            mv[idx]   = 1'b1;
            mpc[idx]  = ex_upd_pc;
            mtgt[idx] = ex_upd_target;
            mctr[idx] = 2;
        end
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; ex_stall = 1'b0; id_stall = 1'b0; ex_redirect = 1'b0;
        id_target_taken = 1'b0; ex_upd_valid = 1'b0; ex_upd_taken = 1'b0;
        ex_redirect_pc = 32'h0; id_target = 32'h0; ex_upd_pc = 32'h0; ex_upd_target = 32'h0;
    endtask

    // One clock: check combinational outputs, clock, advance model, check PCs
    task automatic step();
        logic        pt;
        logic [31:0] tgt, ea, ea0;
        #1;
        ea = 32'h0; ea0 = 32'h0;
        if (!rst) begin
            m_lookup(m_pc, pt, tgt);
            ea  = m_next(m_pc, pt, tgt);
            ea0 = m_next(m_pc0, 1'b0, 32'h0);
            total++; if (if_addr !== ea) begin bad++; $display("FAIL if_addr got=%h exp=%h t=%0t", if_addr, ea, $time); end
            total++; if (if_pred_taken !== pt) begin bad++; $display("FAIL pred_taken got=%b exp=%b t=%0t", if_pred_taken, pt, $time); end
            total++; if (if_pred_target !== tgt) begin bad++; $display("FAIL pred_target got=%h exp=%h t=%0t", if_pred_target, tgt, $time); end
            total++; if (if_addr0 !== ea0) begin bad++; $display("FAIL static_if_addr got=%h exp=%h t=%0t", if_addr0, ea0, $time); end
            total++; if (if_pred_taken0 !== 1'b0 || if_pred_target0 !== 32'h0) begin
                bad++; $display("FAIL static_pred got=%b/%h exp=0/0 t=%0t", if_pred_taken0, if_pred_target0, $time); end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_pc = RST_PC; m_pc0 = RST_PC;
            for (int i = 0; i < NENT; i++) mv[i] = 1'b0;
        end else begin
            m_pc = ea; m_pc0 = ea0;
            m_train();
        end
        total++; if (if_pc !== m_pc) begin bad++; $display("FAIL if_pc got=%h exp=%h t=%0t", if_pc, m_pc, $time); end
        total++; if (if_pc0 !== m_pc0) begin bad++; $display("FAIL static_if_pc got=%h exp=%h t=%0t", if_pc0, m_pc0, $time); end
    endtask

    // Force both instances to fetch a chosen PC next
    task automatic goto(input logic [31:0] pc);
        idle_inputs();
        ex_redirect = 1'b1; ex_redirect_pc = pc;
        step();
        idle_inputs();
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        idle_inputs();
        ex_upd_valid = 1'b1; ex_upd_pc = pc; ex_upd_taken = taken; ex_upd_target = tgt;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        idle_inputs();
        #1;
        total++; if (if_pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", if_pc, RST_PC); end
        total++; if (if_addr !== RST_PC + 32'd4) begin bad++; $display("FAIL reset_addr got=%h exp=%h", if_addr, RST_PC + 32'd4); end
        total++; if (if_pred_taken !== 1'b0 || if_pred_target !== 32'h0) begin
            bad++; $display("FAIL reset_pred got=%b/%h exp=0/0", if_pred_taken, if_pred_target); end
    endtask

    task automatic test_free_run();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        total++; if (if_pc !== 32'h4000_000C) begin bad++; $display("FAIL free_run_pc got=%h exp=4000000c", if_pc); end
    endtask

    task automatic test_train();
        train(32'h4000_0010, 1'b1, 32'h4000_0100);
        goto(32'h4000_0010);
        #1;
        total++; if (if_pred_taken !== 1'b1 || if_addr !== 32'h4000_0100) begin
            bad++; $display("FAIL train_predict got=%b/%h exp=1/40000100", if_pred_taken, if_addr); end
        step();
        train(32'h4000_0010, 1'b0, 32'h0);
        train(32'h4000_0010, 1'b0, 32'h0);
        goto(32'h4000_0010);
        #1;
        total++; if (if_pred_taken !== 1'b0 || if_addr !== 32'h4000_0014) begin
            bad++; $display("FAIL train_untrain got=%b/%h exp=0/40000014", if_pred_taken, if_addr); end
        step();
    endtask

    task automatic test_alias();
        train(32'h4000_0010, 1'b1, 32'h4000_0100);
        train(32'h4000_0050, 1'b1, 32'h4000_0200);
        goto(32'h4000_0010);
        #1;
        total++; if (if_addr !== 32'h4000_0014) begin bad++; $display("FAIL alias_miss got=%h exp=40000014", if_addr); end
        step();
    endtask

    task automatic test_priority();
        idle_inputs();
        ex_redirect = 1'b1; ex_redirect_pc = 32'h4000_0200;
        id_target_taken = 1'b1; id_target = 32'h4000_0300; id_stall = 1'b1;
        #1;
        total++; if (if_addr !== 32'h4000_0200) begin bad++; $display("FAIL prio_redirect got=%h exp=40000200", if_addr); end
        step();
        ex_stall = 1'b1;
        step();
        total++; if (if_pc !== 32'h4000_0200) begin bad++; $display("FAIL prio_ex_stall got=%h exp=40000200", if_pc); end
        ex_stall = 1'b0; ex_redirect = 1'b0;
        step();
        total++; if (if_pc !== 32'h4000_0200) begin bad++; $display("FAIL prio_id_stall got=%h exp=40000200", if_pc); end
        idle_inputs();
        // Unaligned redirect passes through and keeps stepping by 4
        goto(32'h4000_0402);
        step();
        total++; if (if_pc !== 32'h4000_0406) begin bad++; $display("FAIL unaligned got=%h exp=40000406", if_pc); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) train(32'h4000_0020, 1'b1, 32'h4000_0800);
        train(32'h4000_0020, 1'b0, 32'h0);
        goto(32'h4000_0020);
        #1;
        total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL sat_still_taken got=%b exp=1", if_pred_taken); end
        step();
        train(32'h4000_0020, 1'b0, 32'h0);
        goto(32'h4000_0020);
        #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL sat_ctr_two got=%b exp=0", if_pred_taken); end
        step();
    endtask

    task automatic test_redirect_and_update();
        idle_inputs();
        ex_redirect = 1'b1; ex_redirect_pc = 32'h4000_0030;
        ex_upd_valid = 1'b1; ex_upd_pc = 32'h4000_0030; ex_upd_taken = 1'b1; ex_upd_target = 32'h4000_0900;
        step();
        idle_inputs();
        #1;
        total++; if (if_pred_taken !== 1'b1 || if_addr !== 32'h4000_0900) begin
            bad++; $display("FAIL redir_upd got=%b/%h exp=1/40000900", if_pred_taken, if_addr); end
        step();
    endtask

    task automatic test_reset_mid_update();
        idle_inputs();
        rst = 1'b1;
        ex_upd_valid = 1'b1; ex_upd_pc = 32'h4000_0040; ex_upd_taken = 1'b1; ex_upd_target = 32'h4000_0A00;
        step();
        idle_inputs();
        goto(32'h4000_0040);
        #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_upd_discard got=%b exp=0", if_pred_taken); end
        step();
        goto(32'h4000_0030);
        #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_clears got=%b exp=0", if_pred_taken); end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            ex_stall        = ($urandom_range(0, 9) == 0);
            id_stall        = ($urandom_range(0, 7) == 0);
            ex_redirect     = ($urandom_range(0, 7) == 0);
            ex_redirect_pc  = 32'h4000_0000 + ($urandom_range(0, 63) << 2) + (($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0);
            id_target_taken = ($urandom_range(0, 7) == 0);
            id_target       = 32'h4000_0000 + ($urandom_range(0, 63) << 2);
            ex_upd_valid    = ($urandom_range(0, 1) == 1);
            ex_upd_pc       = 32'h4000_0000 + ($urandom_range(0, 63) << 2);
            ex_upd_taken    = ($urandom_range(0, 2) != 0);
            ex_upd_target   = 32'h4000_0000 + ($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 3));
            step();
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < NENT; i++) begin
            mv[i] = 1'b0; mpc[i] = 32'h0; mtgt[i] = 32'h0; mctr[i] = 0;
        end
        m_pc = RST_PC; m_pc0 = RST_PC;
        idle_inputs();
        @(posedge clk);
        test_reset();
        test_free_run();
        test_train();
        test_alias();
        test_priority();
        test_saturate();
        test_redirect_and_update();
        test_reset_mid_update();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
